// File: rtl/nx_host_egress.sv
// Host egress merger: buffers the control-response and mesh-message streams in
// 2-entry FIFOs, merges them round-robin into one tagged host stream, counts deliveries.
module nx_host_egress #(
   parameter int unsigned CTRL_WIDTH  = 31,
   parameter int unsigned MESH_WIDTH  = 31,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [CTRL_WIDTH-1:0]  ctrl_data_i,
   input  logic                   ctrl_valid_i,
   output logic                   ctrl_ready_o,
   input  logic [MESH_WIDTH-1:0]  mesh_data_i,
   input  logic                   mesh_valid_i,
   output logic                   mesh_ready_o,
   output logic [DATA_WIDTH-1:0]  host_data_o,
   output logic                   host_valid_o,
   input  logic                   host_ready_i,
   input  logic                   clear_i,
   output logic [COUNT_WIDTH-1:0] ctrl_count_o,
   output logic [COUNT_WIDTH-1:0] mesh_count_o,
   output logic                   idle_o
);

   localparam int unsigned OCC_WIDTH = 2;
   localparam logic [OCC_WIDTH-1:0]   OCC_EMPTY = OCC_WIDTH'(0);
   localparam logic [OCC_WIDTH-1:0]   OCC_FULL  = OCC_WIDTH'(2);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   logic [CTRL_WIDTH-1:0] ctrl_mem [2];
   logic [MESH_WIDTH-1:0] mesh_mem [2];
   logic                  ctrl_wr_ptr, ctrl_rd_ptr;
   logic                  mesh_wr_ptr, mesh_rd_ptr;
   logic [OCC_WIDTH-1:0]  ctrl_occ, ctrl_occ_nxt;
   logic [OCC_WIDTH-1:0]  mesh_occ, mesh_occ_nxt;
   logic                  last_mesh;

   logic                  ctrl_push, ctrl_pop;
   logic                  mesh_push, mesh_pop;
   logic                  load, grant_mesh;
   logic                  host_hs, host_valid_nxt;
   logic [DATA_WIDTH-1:0] word;

   // Grant, FIFO occupancy and output-word formation
   always_comb begin
      ctrl_push      = ctrl_valid_i && ctrl_ready_o;
      mesh_push      = mesh_valid_i && mesh_ready_o;
      load           = (!host_valid_o || host_ready_i) &&
                       ((ctrl_occ != OCC_EMPTY) || (mesh_occ != OCC_EMPTY));
      // Mesh wins when it is the only source, or on a tie when ctrl went last
      grant_mesh     = (mesh_occ != OCC_EMPTY) && ((ctrl_occ == OCC_EMPTY) || !last_mesh);
      ctrl_pop       = load && !grant_mesh;
      mesh_pop       = load && grant_mesh;
      ctrl_occ_nxt   = ctrl_occ + OCC_WIDTH'(ctrl_push) - OCC_WIDTH'(ctrl_pop);
      mesh_occ_nxt   = mesh_occ + OCC_WIDTH'(mesh_push) - OCC_WIDTH'(mesh_pop);
      host_hs        = host_valid_o && host_ready_i;
      host_valid_nxt = load || (host_valid_o && !host_ready_i);

      word = '0;
      if (grant_mesh) begin
         word[MESH_WIDTH-1:0] = mesh_mem[mesh_rd_ptr];
         word[DATA_WIDTH-1]   = 1'b1;
      end else begin
         word[CTRL_WIDTH-1:0] = ctrl_mem[ctrl_rd_ptr];
      end
   end

   // FIFO storage needs no reset: occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (ctrl_push) ctrl_mem[ctrl_wr_ptr] <= ctrl_data_i;
      if (mesh_push) mesh_mem[mesh_wr_ptr] <= mesh_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_wr_ptr  <= 1'b0;
         ctrl_rd_ptr  <= 1'b0;
         mesh_wr_ptr  <= 1'b0;
         mesh_rd_ptr  <= 1'b0;
         ctrl_occ     <= OCC_EMPTY;
         mesh_occ     <= OCC_EMPTY;
         ctrl_ready_o <= 1'b1;
         mesh_ready_o <= 1'b1;
         last_mesh    <= 1'b1;
         host_valid_o <= 1'b0;
         host_data_o  <= '0;
         idle_o       <= 1'b1;
      end else begin
         if (ctrl_push) ctrl_wr_ptr <= !ctrl_wr_ptr;
         if (ctrl_pop)  ctrl_rd_ptr <= !ctrl_rd_ptr;
         if (mesh_push) mesh_wr_ptr <= !mesh_wr_ptr;
         if (mesh_pop)  mesh_rd_ptr <= !mesh_rd_ptr;
         ctrl_occ     <= ctrl_occ_nxt;
         mesh_occ     <= mesh_occ_nxt;
         ctrl_ready_o <= (ctrl_occ_nxt != OCC_FULL);
         mesh_ready_o <= (mesh_occ_nxt != OCC_FULL);
         if (load) begin
            last_mesh   <= grant_mesh;
            host_data_o <= word;
         end
         host_valid_o <= host_valid_nxt;
         idle_o       <= (ctrl_occ_nxt == OCC_EMPTY) && (mesh_occ_nxt == OCC_EMPTY) &&
                         !host_valid_nxt;
      end
   end

   // Delivery counters: saturate, clear wins over a same-edge delivery
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_count_o <= '0;
         mesh_count_o <= '0;
      end else if (clear_i) begin
         ctrl_count_o <= '0;
         mesh_count_o <= '0;
      end else if (host_hs) begin
         if (host_data_o[DATA_WIDTH-1]) begin
            if (mesh_count_o != COUNT_MAX) mesh_count_o <= mesh_count_o + COUNT_WIDTH'(1);
         end else begin
            if (ctrl_count_o != COUNT_MAX) ctrl_count_o <= ctrl_count_o + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_nx_host_egress.sv
// Randomized and directed bench for nx_host_egress against a queue-based reference model.
module tb_nx_host_egress;

   localparam int unsigned CW   = 6;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [30:0]   ctrl_data = '0;
   logic          ctrl_valid = 1'b0;
   logic          ctrl_ready;
   logic [30:0]   mesh_data = '0;
   logic          mesh_valid = 1'b0;
   logic          mesh_ready;
   logic [31:0]   host_data;
   logic          host_valid;
   logic          host_ready = 1'b0;
   logic          clear = 1'b0;
   logic [CW-1:0] ctrl_count;
   logic [CW-1:0] mesh_count;
   logic          idle;

   int checks = 0;
   int passed = 0;

   // Reference model state
   logic [30:0] m_cq[$];
   logic [30:0] m_mq[$];
   logic        m_ov;
   logic [31:0] m_od;
   logic        m_last_mesh;
   int          m_cc, m_mc;

   nx_host_egress #(
      .CTRL_WIDTH(31), .MESH_WIDTH(31), .DATA_WIDTH(32), .COUNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .ctrl_data_i(ctrl_data), .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready),
      .mesh_data_i(mesh_data), .mesh_valid_i(mesh_valid), .mesh_ready_o(mesh_ready),
      .host_data_o(host_data), .host_valid_o(host_valid), .host_ready_i(host_ready),
      .clear_i(clear), .ctrl_count_o(ctrl_count), .mesh_count_o(mesh_count), .idle_o(idle)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_cq.delete();
      m_mq.delete();
      m_ov        = 1'b0;
      m_od        = '0;
      m_last_mesh = 1'b1;
      m_cc        = 0;
      m_mc        = 0;
   endtask

   // One clock edge: advance the model from the current inputs, then let the DUT clock
   task automatic tick();
      bit hs, c_rdy, m_rdy, ld, gm;
      hs    = m_ov && host_ready;
      c_rdy = m_cq.size() < 2;
      m_rdy = m_mq.size() < 2;
      ld    = (!m_ov || host_ready) && (m_cq.size() > 0 || m_mq.size() > 0);
      if (clear) begin
         m_cc = 0;
         m_mc = 0;
      end else if (hs) begin
         if (m_od[31]) begin if (m_mc < CMAX) m_mc++; end
         else          begin if (m_cc < CMAX) m_cc++; end
      end
      if (ld) begin
         gm = m_mq.size() > 0 && (m_cq.size() == 0 || !m_last_mesh);
         m_od = gm ? {1'b1, m_mq.pop_front()} : {1'b0, m_cq.pop_front()};
         m_ov = 1'b1;
         m_last_mesh = gm;
      end else if (hs) begin
         m_ov = 1'b0;
      end
      if (ctrl_valid && c_rdy) m_cq.push_back(ctrl_data);
      if (mesh_valid && m_rdy) m_mq.push_back(mesh_data);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] model_vec();
      return {1'(m_cq.size() < 2), 1'(m_mq.size() < 2), m_ov, m_od, CW'(m_cc), CW'(m_mc),
              1'(m_cq.size() == 0 && m_mq.size() == 0 && !m_ov)};
   endfunction

   function automatic logic [47:0] dut_vec();
      return {ctrl_ready, mesh_ready, host_valid, host_data, ctrl_count, mesh_count, idle};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ctrl_valid = 1'b0; mesh_valid = 1'b0; host_ready = 1'b0; clear = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec() !== 48'hC000_0000_0001) $display("FAIL reset_vec got %h exp %h", dut_vec(), 48'hC000_0000_0001);
      else passed++;
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_model got %h exp %h", dut_vec(), model_vec());
      else passed++;
   endtask

   task automatic test_single_ctrl();
      do_reset();
      host_ready = 1'b1;
      ctrl_data = 31'h1234_567; ctrl_valid = 1'b1;
      tick();
      ctrl_valid = 1'b0;
      checks++;
      if (host_valid !== 1'b0 || idle !== 1'b0) $display("FAIL latency_early valid=%b idle=%b exp 0 0", host_valid, idle);
      else passed++;
      tick();
      checks++;
      if (host_valid !== 1'b1 || host_data !== 32'h0123_4567) $display("FAIL single_word got %b/%h exp 1/01234567", host_valid, host_data);
      else passed++;
      tick();
      checks++;
      if (ctrl_count !== CW'(1) || idle !== 1'b1 || host_valid !== 1'b0) $display("FAIL single_done cnt=%0d idle=%b valid=%b exp 1 1 0", ctrl_count, idle, host_valid);
      else passed++;
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL single_model got %h exp %h", dut_vec(), model_vec());
      else passed++;
   endtask

   task automatic test_alternate();
      int k = 0;
      do_reset();
      host_ready = 1'b1;
      ctrl_data = 31'hA; ctrl_valid = 1'b1;
      mesh_data = 31'hB; mesh_valid = 1'b1;
      for (int c = 0; c < 28; c++) begin
         if (c == 20) begin ctrl_valid = 1'b0; mesh_valid = 1'b0; end
         tick();
         if (host_valid) begin
            checks++;
            if (host_data !== ((k % 2 == 0) ? 32'h0000_000A : 32'h8000_000B))
               $display("FAIL alt_word[%0d] got %h", k, host_data);
            else passed++;
            k++;
         end
         checks++;
         if (dut_vec() !== model_vec()) $display("FAIL alt_model cyc %0d got %h exp %h", c, dut_vec(), model_vec());
         else passed++;
      end
      checks++;
      if (ctrl_count !== CW'((k + 1) / 2) || mesh_count !== CW'(k / 2))
         $display("FAIL alt_counts got %0d/%0d exp %0d/%0d", ctrl_count, mesh_count, (k + 1) / 2, k / 2);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_q[$];
      do_reset();
      host_ready = 1'b0;
      mesh_data = 31'h55; mesh_valid = 1'b1;
      tick();
      mesh_valid = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (host_valid !== 1'b1 || host_data !== 32'h8000_0055) $display("FAIL hold cyc %0d got %b/%h exp 1/80000055", c, host_valid, host_data);
         else passed++;
      end
      mesh_data = 31'h66; mesh_valid = 1'b1; tick();
      mesh_data = 31'h77; tick();
      mesh_valid = 1'b0;
      checks++;
      if (mesh_ready !== 1'b0) $display("FAIL bp_full mesh_ready got %b exp 0", mesh_ready);
      else passed++;
      exp_q = '{32'h8000_0055, 32'h8000_0066, 32'h8000_0077};
      host_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (host_valid && exp_q.size() > 0) begin
            checks++;
            if (host_data !== exp_q[0]) $display("FAIL drain got %h exp %h", host_data, exp_q[0]);
            else passed++;
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || mesh_count !== CW'(3)) $display("FAIL drain_done left=%0d cnt=%0d exp 0 3", exp_q.size(), mesh_count);
      else passed++;
   endtask

   task automatic test_saturation();
      do_reset();
      host_ready = 1'b1;
      mesh_valid = 1'b1;
      for (int c = 0; c < CMAX + 3; c++) begin
         mesh_data = 31'($urandom);
         tick();
      end
      checks++;
      if (mesh_count !== CW'(CMAX)) $display("FAIL sat_reach got %0d exp %0d", mesh_count, CMAX);
      else passed++;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (mesh_count !== CW'(CMAX) || dut_vec() !== model_vec()) $display("FAIL sat_hold got %0d exp %0d", mesh_count, CMAX);
      else passed++;
      checks++;
      if (host_valid !== 1'b1) $display("FAIL clr_pre valid got %b exp 1", host_valid);
      else passed++;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (mesh_count !== CW'(0) || dut_vec() !== model_vec()) $display("FAIL clr_prio got %0d exp 0", mesh_count);
      else passed++;
   endtask

   task automatic test_async_reset();
      do_reset();
      host_ready = 1'b0;
      ctrl_valid = 1'b1; mesh_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         ctrl_data = 31'($urandom); mesh_data = 31'($urandom);
         tick();
      end
      checks++;
      if (ctrl_ready !== 1'b0 || mesh_ready !== 1'b0 || host_valid !== 1'b1) $display("FAIL ar_full rdy=%b%b valid=%b exp 00 1", ctrl_ready, mesh_ready, host_valid);
      else passed++;
      #3 rst = 1'b1;
      ctrl_valid = 1'b0; mesh_valid = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== 48'hC000_0000_0001) $display("FAIL ar_immediate got %h exp %h", dut_vec(), 48'hC000_0000_0001);
      else passed++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      host_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (host_valid !== 1'b0 || dut_vec() !== model_vec()) $display("FAIL ar_stale cyc %0d got %h exp %h", c, dut_vec(), model_vec());
         else passed++;
      end
   endtask

   task automatic test_single_source();
      logic [30:0] exp_q[$];
      int seen = 0, first = -1, last = -1;
      do_reset();
      host_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         ctrl_valid = (c < 8);
         if (c < 8) begin
            ctrl_data = 31'($urandom);
            exp_q.push_back(ctrl_data);
         end
         tick();
         if (host_valid) begin
            if (first < 0) first = c;
            last = c;
            seen++;
            checks++;
            if (exp_q.size() == 0 || host_data !== {1'b0, exp_q[0]}) $display("FAIL ss_word[%0d] got %h", seen, host_data);
            else passed++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
      ctrl_valid = 1'b0;
      checks++;
      if (seen != 8 || last - first != 7) $display("FAIL ss_bubbles seen=%0d span=%0d exp 8 7", seen, last - first);
      else passed++;
      checks++;
      if (mesh_count !== CW'(0) || ctrl_count !== CW'(8)) $display("FAIL ss_counts got %0d/%0d exp 8/0", ctrl_count, mesh_count);
      else passed++;
      // last grant was ctrl, so the next tie must go to mesh
      host_ready = 1'b0;
      ctrl_data = 31'h1; mesh_data = 31'h2; ctrl_valid = 1'b1; mesh_valid = 1'b1;
      tick();
      ctrl_valid = 1'b0; mesh_valid = 1'b0;
      tick();
      checks++;
      if (host_valid !== 1'b1 || host_data !== 32'h8000_0002) $display("FAIL ss_tie got %b/%h exp 1/80000002", host_valid, host_data);
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ctrl_valid = ($urandom % 3) != 0;
         mesh_valid = ($urandom % 2) != 0;
         ctrl_data  = 31'($urandom);
         mesh_data  = 31'($urandom);
         host_ready = ($urandom % 4) != 0;
         clear      = ($urandom % 60) == 0;
         tick();
         checks++;
         if (dut_vec() !== model_vec()) $display("FAIL rand cyc %0d got %h exp %h", c, dut_vec(), model_vec());
         else passed++;
      end
      clear = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_ctrl();
      test_alternate();
      test_backpressure();
      test_saturation();
      test_async_reset();
      test_single_source();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
